// File: rtl/dec_scan_seq.sv
// Scan sequencer for a downstream 3-to-8 decoder: walks channel codes with a per-channel dwell.
// Optional macro DEC_SCAN_SKIP_EN: visit only mask-enabled channels, with en held high.
module dec_scan_seq #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               en,
    output logic               busy,
    output logic               done
);

    typedef enum logic {StIdle, StScan} state_e;

    state_e             state_q, state_d;
    logic [2:0]         ch_q, ch_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [7:0]         mask_q, mask_d;
    logic               cont_q, cont_d;
    logic               en_q, en_d;
    logic               done_q, done_d;

    logic [2:0]         first_ch, next_ch;
    logic               first_en, next_en, last_ch;

`ifdef DEC_SCAN_SKIP_EN
    logic [7:0] first_src;
    logic       found_first, found_next;

    // First channel comes from the live mask at start, from the captured mask on wrap.
    always_comb begin
        first_src   = (state_q == StIdle) ? mask : mask_q;
        first_ch    = 3'd0;
        next_ch     = ch_q;
        found_first = 1'b0;
        found_next  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (first_src[i] && !found_first) begin
                first_ch    = 3'(i);
                found_first = 1'b1;
            end
            if (mask_q[i] && (i > int'(ch_q)) && !found_next) begin
                next_ch    = 3'(i);
                found_next = 1'b1;
            end
        end
        last_ch  = !found_next;
        first_en = 1'b1;
        next_en  = 1'b1;
    end
`else
    always_comb begin
        first_ch = 3'd0;
        next_ch  = ch_q + 3'd1;
        last_ch  = (ch_q == 3'd7);
        first_en = (state_q == StIdle) ? mask[0] : mask_q[0];
        next_en  = mask_q[next_ch];
    end
`endif

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        en_d    = en_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !stop && (mask != 8'h00)) begin
                    state_d = StScan;
                    mask_d  = mask;
                    dwell_d = dwell;
                    cont_d  = cont;
                    ch_d    = first_ch;
                    cnt_d   = dwell;
                    en_d    = first_en;
                end
            end
            StScan: begin
                if (stop) begin
                    state_d = StIdle;
                    ch_d    = 3'd0;
                    cnt_d   = '0;
                    en_d    = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (!last_ch) begin
                    ch_d  = next_ch;
                    cnt_d = dwell_q;
                    en_d  = next_en;
                end else begin
                    done_d = 1'b1;
                    if (cont_q) begin
                        ch_d  = first_ch;
                        cnt_d = dwell_q;
                        en_d  = first_en;
                    end else begin
                        state_d = StIdle;
                        ch_d    = 3'd0;
                        cnt_d   = '0;
                        en_d    = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ch_q    <= 3'd0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= 8'h00;
            cont_q  <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign {a, b, c} = ch_q;
    assign en        = en_q;
    assign busy      = (state_q == StScan);
    assign done      = done_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Self-checking bench for dec_scan_seq: pass-trace reference model plus directed literal checks.
// Honours DEC_SCAN_SKIP_EN the same way the design does.
module tb_dec_scan_seq;

    localparam int unsigned DW = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop  = 1'b0;
    logic          cont  = 1'b0;
    logic [7:0]    mask  = 8'h00;
    logic [DW-1:0] dwell = '0;
    logic          a, b, c, en, busy, done;

    int n_pass  = 0;
    int n_total = 0;

    dec_scan_seq #(.DWELL_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .cont  (cont),
        .mask  (mask),
        .dwell (dwell),
        .a     (a),
        .b     (b),
        .c     (c),
        .en    (en),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Reference: a whole pass is expanded into a queue of {en, code} entries, one per cycle.
    logic [3:0] pass_q[$];
    logic       m_busy  = 1'b0;
    logic       m_cont  = 1'b0;
    logic [7:0] m_mask  = 8'h00;
    int         m_dwell = 0;
    logic [5:0] exp_out = 6'b0;

    function automatic void build_pass();
        pass_q.delete();
        for (int ch = 0; ch < 8; ch++) begin
`ifdef DEC_SCAN_SKIP_EN
            if (m_mask[ch])
                for (int k = 0; k <= m_dwell; k++) pass_q.push_back({1'b1, 3'(ch)});
`else
            for (int k = 0; k <= m_dwell; k++) pass_q.push_back({m_mask[ch], 3'(ch)});
`endif
        end
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b at %0t", nm, act[5:0], exp[5:0], $time);
    endtask

    function automatic int outs();
        return int'({a, b, c, en, busy, done});
    endfunction

    // Outputs packed as {a,b,c,en,busy,done}.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_busy = 1'b0;
                pass_q.delete();
                exp_out = 6'b0;
            end else if (!m_busy) begin
                if (start && !stop && (mask != 8'h00)) begin
                    m_mask  = mask;
                    m_dwell = int'(dwell);
                    m_cont  = cont;
                    build_pass();
                    e       = pass_q.pop_front();
                    m_busy  = 1'b1;
                    exp_out = {e[2:0], e[3], 2'b10};
                end else begin
                    exp_out = 6'b0;
                end
            end else if (stop) begin
                m_busy  = 1'b0;
                exp_out = 6'b0;
            end else if (pass_q.size() != 0) begin
                e       = pass_q.pop_front();
                exp_out = {e[2:0], e[3], 2'b10};
            end else if (m_cont) begin
                build_pass();
                e       = pass_q.pop_front();
                exp_out = {e[2:0], e[3], 2'b11};
            end else begin
                m_busy  = 1'b0;
                exp_out = 6'b000001;
            end
            #1;
            check("model", outs(), int'(exp_out));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // After return the first channel of the pass is on the outputs.
    task automatic go(input logic [7:0] m, input int d, input logic ct);
        start = 1'b1;
        mask  = m;
        dwell = DW'(d);
        cont  = ct;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int nb, nd;
        cyc();
        cyc();
        check("reset_state", outs(), 0);
        rst_n = 1'b1;
        cyc();
        check("idle_after_reset", outs(), 0);

        // FF, dwell 0, single pass
        go(8'hFF, 0, 1'b0);
        check("ff_first_code", outs(), 6'b000_1_1_0);
        repeat (7) cyc();
        check("ff_last_code", outs(), 6'b111_1_1_0);
        cyc();
        check("ff_done", outs(), 6'b000_0_0_1);
        cyc();
        check("ff_done_once", outs(), 0);

        // FF, dwell 2: 24 busy cycles, one done
        go(8'hFF, 2, 1'b0);
        nb = 0;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            nb += int'(busy);
            nd += int'(done);
            cyc();
        end
        check("dwell2_busy_cycles", nb, 24);
        check("dwell2_done_count", nd, 1);

        // mask 81
        go(8'h81, 0, 1'b0);
        check("m81_first", outs(), 6'b000_1_1_0);
        cyc();
`ifdef DEC_SCAN_SKIP_EN
        check("m81_second", outs(), 6'b111_1_1_0);
        cyc();
        check("m81_done", outs(), 6'b000_0_0_1);
`else
        check("m81_second", outs(), 6'b001_0_1_0);
        repeat (6) cyc();
        check("m81_last", outs(), 6'b111_1_1_0);
`endif
        repeat (4) cyc();

        // continuous scan, wrap and stop
        go(8'hFF, 0, 1'b1);
        check("cont_first", outs(), 6'b000_1_1_0);
        repeat (8) cyc();
        check("cont_wrap_done", outs(), 6'b000_1_1_1);
        repeat (3) cyc();
        check("cont_code3", outs(), 6'b011_1_1_0);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("stop_idle", outs(), 0);
        cont = 1'b0;

        // mask 00 start ignored; start during scan ignored
        go(8'h00, 0, 1'b0);
        check("mask0_ignored", outs(), 0);
        go(8'hFF, 3, 1'b0);
        cyc();
        start = 1'b1;
        mask  = 8'h01;
        dwell = DW'(0);
        cyc();
        start = 1'b0;
        check("no_restart", outs(), 6'b000_1_1_0);
        repeat (40) cyc();

        // asynchronous reset at code 5
        go(8'hFF, 0, 1'b0);
        repeat (5) cyc();
        check("pre_reset_code5", outs(), 6'b101_1_1_0);
        #1 rst_n = 1'b0;
        #1 check("async_reset", outs(), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_reset_idle", outs(), 0);
        repeat (3) cyc();
        check("post_reset_still_idle", outs(), 0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 24) == 0);
            cont  = 1'($urandom_range(0, 1));
            mask  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            dwell = DW'($urandom_range(0, 3));
            cyc();
        end
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
